// File: rtl/mm_tile_ctrl.sv
// Tile sequencer for a systolic matrix-multiply array: walks a job of tiles through
// feed, skew drain and result store, with per-tile buffer base addresses.
module mm_tile_ctrl #(
  parameter int ADDR_WIDTH = 16,
  parameter int ARRAY_N    = 8,
  parameter int ARRAY_M    = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [ADDR_WIDTH-1:0]      cfg_a_base,
  input  logic [ADDR_WIDTH-1:0]      cfg_a_stride,
  input  logic [ADDR_WIDTH-1:0]      cfg_b_base,
  input  logic [ADDR_WIDTH-1:0]      cfg_b_stride,
  input  logic [CNT_WIDTH-1:0]       cfg_num_tiles,
  input  logic [CNT_WIDTH-1:0]       cfg_feed_len,
  input  logic [$clog2(ARRAY_N):0]   cfg_num_rows,
  output logic                       abuf_on,
  output logic [ADDR_WIDTH-1:0]      abuf_base_addr,
  output logic [$clog2(ARRAY_N):0]   abuf_num_rows,
  output logic                       bbuf_on,
  output logic [ADDR_WIDTH-1:0]      bbuf_base_addr,
  output logic                       acc_clear,
  output logic                       acc_store,
  output logic [CNT_WIDTH-1:0]       tile_idx,
  output logic                       busy,
  output logic                       done
);

  localparam int RW = $clog2(ARRAY_N) + 1;
  localparam logic [RW-1:0]        ROWS_MAX   = RW'(ARRAY_N);
  localparam logic [CNT_WIDTH-1:0] ONE        = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] DRAIN_LAST = CNT_WIDTH'(ARRAY_N + ARRAY_M - 2);

  typedef enum logic [2:0] {IDLE, FEED, DRAIN, STORE, FIN} state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_a_stride;
  logic [ADDR_WIDTH-1:0] r_b_stride;
  logic [CNT_WIDTH-1:0]  r_num_tiles;
  logic [CNT_WIDTH-1:0]  r_feed_len;
  logic [CNT_WIDTH-1:0]  r_cnt;

  logic          w_cfg_zero;
  logic [RW-1:0] w_rows_clamped;
  logic          w_feed_last;
  logic          w_drain_last;
  logic          w_tile_last;

  assign w_cfg_zero     = (cfg_num_tiles == '0) || (cfg_feed_len == '0) || (cfg_num_rows == '0);
  assign w_rows_clamped = (cfg_num_rows > ROWS_MAX) ? ROWS_MAX : cfg_num_rows;
  assign w_feed_last    = (r_cnt == r_feed_len - ONE);
  assign w_drain_last   = (r_cnt == DRAIN_LAST);
  assign w_tile_last    = (tile_idx == r_num_tiles - ONE);

  // Outputs are set on the transition into each state, so they are registered
  // and line up with the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= IDLE;
      r_a_stride     <= '0;
      r_b_stride     <= '0;
      r_num_tiles    <= '0;
      r_feed_len     <= '0;
      r_cnt          <= '0;
      abuf_on        <= 1'b0;
      bbuf_on        <= 1'b0;
      abuf_base_addr <= '0;
      bbuf_base_addr <= '0;
      abuf_num_rows  <= '0;
      acc_clear      <= 1'b0;
      acc_store      <= 1'b0;
      tile_idx       <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a_stride     <= cfg_a_stride;
            r_b_stride     <= cfg_b_stride;
            r_num_tiles    <= cfg_num_tiles;
            r_feed_len     <= cfg_feed_len;
            r_cnt          <= '0;
            tile_idx       <= '0;
            abuf_base_addr <= cfg_a_base;
            bbuf_base_addr <= cfg_b_base;
            if (w_cfg_zero) begin
              r_state <= FIN;
              done    <= 1'b1;
            end else begin
              r_state       <= FEED;
              busy          <= 1'b1;
              abuf_on       <= 1'b1;
              bbuf_on       <= 1'b1;
              acc_clear     <= 1'b1;
              abuf_num_rows <= w_rows_clamped;
            end
          end
        end
        FEED: begin
          acc_clear <= 1'b0;
          if (w_feed_last) begin
            r_state <= DRAIN;
            abuf_on <= 1'b0;
            bbuf_on <= 1'b0;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + ONE;
          end
        end
        DRAIN: begin
          if (w_drain_last) begin
            r_state   <= STORE;
            acc_store <= 1'b1;
            r_cnt     <= '0;
          end else begin
            r_cnt <= r_cnt + ONE;
          end
        end
        STORE: begin
          acc_store <= 1'b0;
          if (w_tile_last) begin
            r_state       <= FIN;
            busy          <= 1'b0;
            done          <= 1'b1;
            abuf_num_rows <= '0;
          end else begin
            // Stride accumulation keeps base + idx*stride without a multiplier.
            r_state        <= FEED;
            tile_idx       <= tile_idx + ONE;
            abuf_base_addr <= abuf_base_addr + r_a_stride;
            bbuf_base_addr <= bbuf_base_addr + r_b_stride;
            abuf_on        <= 1'b1;
            bbuf_on        <= 1'b1;
            acc_clear      <= 1'b1;
          end
        end
        FIN: begin
          done    <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mm_tile_ctrl.sv
// Self-checking bench for mm_tile_ctrl: directed and random jobs compared cycle by
// cycle against a tile-level schedule model.
module tb_mm_tile_ctrl;

  localparam int AW = 16;
  localparam int N  = 8;
  localparam int M  = 8;
  localparam int CW = 16;
  localparam int RW = $clog2(N) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] cfg_a_base = '0, cfg_a_stride = '0, cfg_b_base = '0, cfg_b_stride = '0;
  logic [CW-1:0] cfg_num_tiles = '0, cfg_feed_len = '0;
  logic [RW-1:0] cfg_num_rows = '0;
  logic          abuf_on, bbuf_on, acc_clear, acc_store, busy, done;
  logic [AW-1:0] abuf_base_addr, bbuf_base_addr;
  logic [RW-1:0] abuf_num_rows;
  logic [CW-1:0] tile_idx;

  mm_tile_ctrl #(.ADDR_WIDTH(AW), .ARRAY_N(N), .ARRAY_M(M), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .start(start),
    .cfg_a_base(cfg_a_base), .cfg_a_stride(cfg_a_stride),
    .cfg_b_base(cfg_b_base), .cfg_b_stride(cfg_b_stride),
    .cfg_num_tiles(cfg_num_tiles), .cfg_feed_len(cfg_feed_len), .cfg_num_rows(cfg_num_rows),
    .abuf_on(abuf_on), .abuf_base_addr(abuf_base_addr), .abuf_num_rows(abuf_num_rows),
    .bbuf_on(bbuf_on), .bbuf_base_addr(bbuf_base_addr),
    .acc_clear(acc_clear), .acc_store(acc_store), .tile_idx(tile_idx),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          a_on, b_on, clr, st, dn, bsy;
    logic [RW-1:0] rows;
    logic [CW-1:0] tile;
    logic [AW-1:0] aa, ba;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Addresses and tile index are only defined while busy, so they are masked otherwise.
  function automatic logic [63:0] dut_vec(input bit full);
    exp_t v;
    v = '{abuf_on, bbuf_on, acc_clear, acc_store, done, busy, abuf_num_rows,
          tile_idx, abuf_base_addr, bbuf_base_addr};
    if (!full) begin
      v.tile = '0; v.aa = '0; v.ba = '0;
    end
    return 64'(v);
  endfunction

  function automatic logic [63:0] exp_vec(input exp_t e);
    exp_t v;
    v = e;
    if (!e.bsy) begin
      v.tile = '0; v.aa = '0; v.ba = '0;
    end
    return 64'(v);
  endfunction

  // Expected per-cycle schedule from cycle 1 onward, written per tile with explicit products.
  task automatic build(input logic [AW-1:0] ab, as, bb, bs, input int nt, fl, nr);
    exp_t e;
    int   rc;
    q.delete();
    rc = (nr > N) ? N : nr;
    if (nt != 0 && fl != 0 && nr != 0) begin
      for (int t = 0; t < nt; t++) begin
        for (int k = 0; k < fl + N + M; k++) begin
          e      = '0;
          e.bsy  = 1'b1;
          e.rows = RW'(rc);
          e.tile = CW'(t);
          e.aa   = AW'(int'(ab) + t * int'(as));
          e.ba   = AW'(int'(bb) + t * int'(bs));
          e.a_on = (k < fl);
          e.b_on = (k < fl);
          e.clr  = (k == 0);
          e.st   = (k == fl + N + M - 1);
          q.push_back(e);
        end
      end
    end
    e = '0; e.dn = 1'b1;
    q.push_back(e);
    for (int i = 0; i < 3; i++) q.push_back(exp_t'(0));
  endtask

  // inject_c: cycle at which start is pulsed with scrambled cfg; abort_c: cycle at which reset is raised.
  task automatic run_job(input string tag, input logic [AW-1:0] ab, as, bb, bs,
                         input int nt, fl, nr, inject_c, abort_c);
    build(ab, as, bb, bs, nt, fl, nr);
    @(negedge clk);
    cfg_a_base = ab; cfg_a_stride = as; cfg_b_base = bb; cfg_b_stride = bs;
    cfg_num_tiles = CW'(nt); cfg_feed_len = CW'(fl); cfg_num_rows = RW'(nr);
    start = 1'b1;
    for (int c = 1; c <= q.size(); c++) begin
      @(negedge clk);
      if (c == 1 || c == inject_c + 1) start = 1'b0;
      chk($sformatf("%s c%0d", tag, c), dut_vec(q[c-1].bsy), exp_vec(q[c-1]));
      if (c == inject_c) begin
        start = 1'b1;
        cfg_a_base = AW'($urandom); cfg_a_stride = AW'($urandom);
        cfg_num_tiles = CW'($urandom_range(1, 5)); cfg_feed_len = CW'($urandom_range(1, 9));
        cfg_num_rows = RW'($urandom_range(1, 8));
      end
      if (c == abort_c) begin
        reset = 1'b1;
        @(negedge clk);
        chk($sformatf("%s reset", tag), dut_vec(1'b1), 64'd0);
        reset = 1'b0;
        start = 1'b0;
        return;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("reset state", dut_vec(1'b1), 64'd0);
    start = 1'b1;
    @(negedge clk);
    chk("start with reset", dut_vec(1'b1), 64'd0);
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("idle after reset", dut_vec(1'b1), 64'd0);

    run_job("single",  16'd16,   16'd0,    16'd0, 16'd0, 1, 16, 4,  -1, -1);
    run_job("multi",   16'h0100, 16'h0040, 16'd0, 16'd8, 3, 4,  8,  -1, -1);
    run_job("wrap",    16'hFFF0, 16'h0020, 16'd5, 16'd3, 2, 3,  2,  -1, -1);
    run_job("deg_nt",  16'd1,    16'd1,    16'd1, 16'd1, 0, 5,  3,  -1, -1);
    run_job("deg_fl",  16'd1,    16'd1,    16'd1, 16'd1, 2, 0,  3,  -1, -1);
    run_job("deg_nr",  16'd1,    16'd1,    16'd1, 16'd1, 2, 5,  0,  -1, -1);
    run_job("clamp",   16'h0200, 16'h0010, 16'h40, 16'h4, 2, 6, 12, 3,  -1);
    // Start pulsed in the FIN cycle (1 + 1*(2+N+M)) must not launch a job.
    run_job("fin_start", 16'h30, 16'h0, 16'h0, 16'h0, 1, 2, 5, 1 + 2 + N + M, -1);
    run_job("abort",   16'h0300, 16'h0010, 16'h0, 16'h1, 2, 8, 6,  -1, 5);
    @(negedge clk);
    chk("idle after abort", dut_vec(1'b1), 64'd0);
    run_job("after_abort", 16'h0400, 16'h0, 16'h10, 16'h0, 1, 5, 7, -1, -1);

    for (int j = 0; j < 10; j++) begin
      run_job($sformatf("rnd%0d", j), AW'($urandom), AW'($urandom), AW'($urandom), AW'($urandom),
              ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 3)),
              ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 6)),
              int'($urandom_range(0, 15)), -1, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mm_tile_ctrl.md
MM_TILE_CTRL -- requirements
Module: mm_tile_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 16, meaning the buffer address width.
REQ-002 The block SHALL have parameter ARRAY_N, default 8, meaning the systolic array rows (the A-buffer lanes).
REQ-003 The block SHALL have parameter ARRAY_M, default 8, meaning the systolic array columns.
REQ-004 The block SHALL have parameter CNT_WIDTH, default 16, meaning the width of the tile and feed counters.
REQ-005 The block SHALL have these ports, with clock and reset first:
- clk  in  1  single clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a job.
- cfg_a_base  in  ADDR_WIDTH  A-buffer base address of tile 0.
- cfg_a_stride  in  ADDR_WIDTH  A address increment per tile.
- cfg_b_base  in  ADDR_WIDTH  B-buffer base address of tile 0.
- cfg_b_stride  in  ADDR_WIDTH  B address increment per tile.
- cfg_num_tiles  in  CNT_WIDTH  number of tiles in the job.
- cfg_feed_len  in  CNT_WIDTH  feed cycles per tile.
- cfg_num_rows  in  $clog2(ARRAY_N)+1  active A rows.
- abuf_on  out  1  A-buffer stream enable.
- abuf_base_addr  out  ADDR_WIDTH  A-buffer base address.
- abuf_num_rows  out  $clog2(ARRAY_N)+1  A-buffer row count.
- bbuf_on  out  1  B-buffer stream enable.
- bbuf_base_addr  out  ADDR_WIDTH  B-buffer base address.
- acc_clear  out  1  clears the array accumulators.
- acc_store  out  1  commits the array results.
- tile_idx  out  CNT_WIDTH  index of the current tile.
- busy  out  1  a job is in progress.
- done  out  1  one-cycle pulse at job completion.

Function
REQ-006 The FSM SHALL have states IDLE, FEED, DRAIN, STORE and FIN, all registered.
REQ-007 In IDLE, start=1 SHALL latch all cfg_* inputs and set tile_idx=0.
- Next state is FIN if cfg_num_tiles=0, cfg_feed_len=0 or cfg_num_rows=0.
- Otherwise next state is FEED.
REQ-008 The block SHALL ignore start and all cfg_* changes outside IDLE; it SHALL use only the latched copies.
REQ-009 The latched num_rows SHALL be clamped to ARRAY_N when the input exceeds ARRAY_N.
REQ-010 FEED SHALL last exactly feed_len cycles, with abuf_on=1 and bbuf_on=1 on every one of those cycles.
REQ-011 acc_clear SHALL be 1 on the first FEED cycle of each tile only.
REQ-012 For the whole tile, the addresses SHALL be held constant at these values, computed modulo 2^ADDR_WIDTH (wrap, no saturation):
- abuf_base_addr = a_base + tile_idx*a_stride.
- bbuf_base_addr = b_base + tile_idx*b_stride.
REQ-013 The running addresses SHALL be updated by adding the stride at the tile boundary; no multiplier SHALL be used.
REQ-014 abuf_num_rows SHALL equal the latched, clamped num_rows while busy=1, and 0 otherwise.
REQ-015 DRAIN SHALL last exactly ARRAY_N+ARRAY_M-1 cycles with abuf_on=0 and bbuf_on=0; this flushes the systolic skew.
REQ-016 STORE SHALL last 1 cycle with acc_store=1.
REQ-017 After STORE, the next state SHALL be:
- FIN if tile_idx = num_tiles-1;
- otherwise FEED, with tile_idx incremented.
REQ-018 FIN SHALL last 1 cycle with done=1 and busy=0, then go to IDLE.
REQ-019 A start sampled in the FIN cycle SHALL be ignored.
REQ-020 busy SHALL be 1 in FEED, DRAIN and STORE, and 0 in IDLE and FIN.
REQ-021 Timing: for start sampled at cycle 0 with T≥1 tiles:
- the first FEED cycle is cycle 1;
- each tile takes feed_len+ARRAY_N+ARRAY_M cycles;
- done=1 at cycle 1+T*(feed_len+ARRAY_N+ARRAY_M).
REQ-022 A degenerate job (REQ-007 FIN path) SHALL assert done at cycle 1 with no on, clear or store pulses.
REQ-023 All outputs SHALL be driven from registers.
REQ-024 abuf_on, bbuf_on, acc_clear, acc_store and done SHALL never be asserted in IDLE.

Reset
REQ-025 reset=1 SHALL, at the next clock edge and from any state including mid-FEED, force the following:
- state IDLE;
- every output 0;
- tile_idx 0;
- all counters and latched config cleared.
REQ-026 A start asserted together with reset SHALL be ignored.
REQ-027 The first start sampled with reset=0 SHALL begin a job normally.

Verification
REQ-028 A bench SHALL cover the single-tile case:
- stimulus: N=M=8, a_base=16, num_rows=4, feed_len=16, tiles=1, start at cycle 0;
- response: abuf_on=1 in cycles 1-16 with abuf_base_addr=16 and abuf_num_rows=4, acc_clear at 1, acc_store at 32, done at 33.
REQ-029 A bench SHALL cover the multi-tile case:
- stimulus: tiles=3, a_base=0x0100, a_stride=0x0040, b_base=0, b_stride=8, feed_len=4;
- response: A addresses 0x0100, 0x0140 and 0x0180, B addresses 0, 8 and 16, tile_idx 0, 1 and 2, done at cycle 61.
REQ-030 A bench SHALL cover address wrap:
- stimulus: a_base=0xFFF0, a_stride=0x0020, tiles=2;
- response: the second tile has abuf_base_addr=0x0010.
REQ-031 A bench SHALL cover degenerate jobs:
- stimulus: tiles=0 (separately feed_len=0, separately num_rows=0);
- response: done at cycle 1, busy never 1, no on, clear or store pulses.
REQ-032 A bench SHALL cover clamping and ignored inputs:
- stimulus: num_rows=12 with N=8; then start and a cfg change during FEED;
- response: abuf_num_rows=8; the job is unaffected and no second job starts.
REQ-033 A bench SHALL cover reset mid-job:
- stimulus: reset at cycle 5 of FEED, then start with tiles=1;
- response: all outputs 0 on the next cycle; the new job runs fully with tile_idx=0.
